// File: rtl/arith_pipe.sv
// Two-stage pipelined add/sub/inc/dec/saturate/accumulate unit with valid/ready
// handshakes on both sides and a sticky overflow flag.
module arith_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       code,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             vout,
  output logic             cout,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned W1  = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_code;
  logic             s1_cin;
  logic [WIDTH-1:0] acc;

  logic             advance;
  logic             accept;
  logic [W1-1:0]    sum_add;
  logic [W1-1:0]    sum_sub;
  logic [WIDTH-1:0] sum_plain;
  logic [WIDTH-1:0] sum_acc;
  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_co;
  logic             sat_ovf;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  // Stage 2 datapath, evaluated on the stage 1 contents
  always_comb begin
    sum_add   = {1'b0, s1_a} + {1'b0, s1_b} + W1'(s1_cin);
    sum_sub   = {1'b0, s1_a} - {1'b0, s1_b};
    sum_plain = s1_a + s1_b;
    sum_acc   = acc + s1_a;
    sat_ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum_plain[MSB] != s1_a[MSB]);
    res       = '0;
    res_v     = 1'b0;
    res_co    = 1'b0;
    case (s1_code)
      3'b000: begin
        res   = sum_add[WIDTH-1:0];
        res_v = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      3'b001: begin
        res    = sum_add[WIDTH-1:0];
        res_co = sum_add[WIDTH];
      end
      3'b010: begin
        res   = sum_sub[WIDTH-1:0];
        res_v = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      3'b011: begin
        res    = sum_sub[WIDTH-1:0];
        res_co = sum_sub[WIDTH];
      end
      3'b100: begin
        res   = s1_a + WIDTH'(1);
        res_v = (s1_a == MAX_POS);
      end
      3'b101: begin
        res   = s1_a - WIDTH'(1);
        res_v = (s1_a == MIN_NEG);
      end
      3'b110: begin
        res   = sat_ovf ? (s1_a[MSB] ? MIN_NEG : MAX_POS) : sum_plain;
        res_v = sat_ovf;
      end
      default: begin
        res   = sum_acc;
        res_v = (acc[MSB] == s1_a[MSB]) && (sum_acc[MSB] != acc[MSB]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_code   <= '0;
      s1_cin    <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
      vout      <= 1'b0;
      cout      <= 1'b0;
      acc       <= '0;
      sticky_v  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_code  <= code;
        s1_cin   <= cin;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      // Result registers only move when the consumer side can take a new one
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          c    <= res;
          vout <= res_v;
          cout <= res_co;
          if (s1_code == 3'b111) acc <= sum_acc;
        end
      end
      if (out_valid && out_ready && vout) sticky_v <= 1'b1;
      else if (clr_sticky)                sticky_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_pipe.sv
// Directed bench for arith_pipe: opcode boundaries, accumulate chaining, reset,
// backpressure ordering/stability, sticky flag and an 8-bit instance.
module tb_arith_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  code = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] c;
  logic        vout;
  logic        cout;
  logic        sticky_v;
  logic        clr_sticky = 1'b0;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [2:0]  code8 = '0;
  logic        cin8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  c8;
  logic        vout8;
  logic        cout8;
  logic        sticky_v8;
  logic        clr_sticky8 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arith_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .code(code), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .vout(vout), .cout(cout),
    .sticky_v(sticky_v), .clr_sticky(clr_sticky)
  );

  arith_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .code(code8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .vout(vout8), .cout(cout8),
    .sticky_v(sticky_v8), .clr_sticky(clr_sticky8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready high: checks the two-edge latency and the result
  task automatic op16(input string tag, input logic [2:0] cd, input logic [15:0] aa,
                      input logic [15:0] bb, input logic ci, input logic [15:0] ec,
                      input logic ev, input logic eco);
    in_valid  = 1'b1;
    code      = cd;
    a         = aa;
    b         = bb;
    cin       = ci;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_c"}, 32'(c), 32'(ec));
    chk({tag, "_vout"}, 32'(vout), 32'(ev));
    chk({tag, "_cout"}, 32'(cout), 32'(eco));
  endtask

  logic [15:0] expq[$];
  logic [15:0] held;
  logic [15:0] exp_c;
  logic        stall;
  logic        hs_in;
  logic        hs_out;
  logic        m_s1;
  logic        m_ov;
  logic        m_adv;
  logic [7:0]  pat;
  int          issued;
  int          got;

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_vout", 32'(vout), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_sticky", 32'(sticky_v), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Adds, subtract, inc/dec boundaries
    op16("sadd_ovf", 3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0);
    op16("uadd_carry", 3'b001, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1);
    op16("usub_borrow", 3'b011, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b1);
    op16("ssub_ovf", 3'b010, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    op16("inc_ovf", 3'b100, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b1, 1'b0);
    op16("dec_ovf", 3'b101, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    op16("dec_plain", 3'b101, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Saturation
    op16("sat_pos", 3'b110, 16'h7000, 16'h2000, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    op16("sat_neg", 3'b110, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0);
    op16("sat_none", 3'b110, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);

    // Back-to-back accumulate
    tick();
    code = 3'b111; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0005;
    tick();
    a = 16'h0003;
    tick();
    chk("acc1_valid", 32'(out_valid), 32'd1);
    chk("acc1_c", 32'(c), 32'h0005);
    a = 16'hFFFE;
    tick();
    in_valid = 1'b0;
    chk("acc2_c", 32'(c), 32'h0008);
    tick();
    chk("acc3_c", 32'(c), 32'h0006);
    chk("acc3_vout", 32'(vout), 32'd0);

    // Reset mid-operation discards the pipe and the accumulator
    in_valid = 1'b1; a = 16'h0100;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    op16("acc_after_rst", 3'b111, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
    tick();

    // Backpressure stream of six ops, out_ready pattern 1,0,0,1,0,1,1,1 then high
    pat = 8'b1110_1001;
    issued = 0;
    got = 0;
    m_s1 = 1'b0;
    m_ov = 1'b0;
    for (int k = 0; k < 40 && got < 6; k++) begin
      in_valid  = (issued < 6);
      code      = 3'b001;
      a         = 16'(issued * 16'h0111);
      b         = 16'h0001;
      cin       = 1'b0;
      out_ready = (k < 8) ? pat[k] : 1'b1;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(m_s1 && m_ov && !out_ready)));
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        exp_c = (expq.size() > 0) ? expq.pop_front() : 16'hDEAD;
        chk("bp_order", 32'(c), 32'(exp_c));
        got++;
      end
      stall = out_valid && !out_ready;
      held  = c;
      if (hs_in) begin
        expq.push_back(a + 16'h0001);
        issued++;
      end
      m_adv = !m_ov || out_ready;
      m_ov  = m_adv ? m_s1 : m_ov;
      m_s1  = hs_in ? 1'b1 : (m_adv ? 1'b0 : m_s1);
      tick();
      if (stall) chk("bp_stable", 32'(c), 32'(held));
      chk("bp_out_valid", 32'(out_valid), 32'(m_ov));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd6);
    tick();

    // Sticky overflow flag
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr0", 32'(sticky_v), 32'd0);
    op16("st_ovf", 3'b110, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    op16("st_plain", 3'b110, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);
    chk("sticky_set", 32'(sticky_v), 32'd1);
    tick();
    chk("sticky_hold", 32'(sticky_v), 32'd1);
    op16("st_ovf2", 3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_set_wins", 32'(sticky_v), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", 32'(sticky_v), 32'd0);

    // 8-bit instance
    in_valid8 = 1'b1; code8 = 3'b000; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    chk("w8_early", 32'(out_valid8), 32'd0);
    tick();
    chk("w8_valid", 32'(out_valid8), 32'd1);
    chk("w8_c", 32'(c8), 32'h80);
    chk("w8_vout", 32'(vout8), 32'd1);
    chk("w8_cout", 32'(cout8), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
